// File: rtl/tia_playfield_serializer.sv
// Playfield serializer: shifts a PF_BITS-wide pattern out one bit per CELL_CLKS clocks,
// left half in ascending order, right half either repeated or mirrored.
module tia_playfield_serializer #(
  parameter int PF_BITS   = 20,
  parameter int CELL_CLKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       reflect,
  input  logic       line_start,
  output logic       pf_out,
  output logic       active,
  output logic       right_half
);

  localparam int IDX_W = $clog2(PF_BITS);
  localparam int CNT_W = (CELL_CLKS > 1) ? $clog2(CELL_CLKS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PF_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_CLKS - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_e;

  state_e             state_q, state_d;
  logic [PF_BITS-1:0] pf_reg_q, pf_reg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               refl_q, refl_d;
  logic               pf_out_q, pf_out_d;
  logic               active_q, right_q;

  // Each pattern bit belongs to lane gi/8; lane bits beyond PF_BITS simply have no storage.
  genvar gi;
  generate
    for (gi = 0; gi < PF_BITS; gi++) begin : g_wr
      localparam int LANE = gi / 8;
      assign pf_reg_d[gi] = (wr_en && (wr_addr == 2'(LANE))) ? wr_data[gi % 8] : pf_reg_q[gi];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    refl_d   = refl_q;
    pf_out_d = pf_out_q;
    if (line_start) begin
      // Pixel loads read pf_reg_q, so a write on this same edge is not yet visible.
      state_d  = LEFT;
      idx_d    = '0;
      cnt_d    = '0;
      pf_out_d = pf_reg_q[0];
    end else if (state_q == IDLE) begin
      pf_out_d = 1'b0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      if (state_q == LEFT) begin
        if (idx_q == IDX_LAST) begin
          state_d = RIGHT;
          refl_d  = reflect;
          idx_d   = reflect ? IDX_LAST : '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        pf_out_d = pf_reg_q[idx_d];
      end else if (refl_q ? (idx_q == '0) : (idx_q == IDX_LAST)) begin
        state_d  = IDLE;
        idx_d    = '0;
        pf_out_d = 1'b0;
      end else begin
        idx_d    = refl_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
        pf_out_d = pf_reg_q[idx_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pf_reg_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      refl_q   <= 1'b0;
      pf_out_q <= 1'b0;
      active_q <= 1'b0;
      right_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pf_reg_q <= pf_reg_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      refl_q   <= refl_d;
      pf_out_q <= pf_out_d;
      active_q <= (state_d != IDLE);
      right_q  <= (state_d == RIGHT);
    end
  end

  assign pf_out     = pf_out_q;
  assign active     = active_q;
  assign right_half = right_q;

endmodule

// File: tb/tb_tia_playfield_serializer.sv
// Bench for tia_playfield_serializer: a default-sized instance (a) and an 8-bit, 1-clock-cell instance (b).
module tb_tia_playfield_serializer;

  typedef struct packed {
    logic pf;
    logic act;
    logic rh;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en_a, reflect_a, line_start_a, pf_a, act_a, rh_a;
  logic [1:0] wr_addr_a;
  logic [7:0] wr_data_a;
  logic       wr_en_b, reflect_b, line_start_b, pf_b, act_b, rh_b;
  logic [1:0] wr_addr_b;
  logic [7:0] wr_data_b;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  tia_playfield_serializer #(.PF_BITS(20), .CELL_CLKS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .reflect(reflect_a), .line_start(line_start_a), .pf_out(pf_a), .active(act_a), .right_half(rh_a)
  );

  tia_playfield_serializer #(.PF_BITS(8), .CELL_CLKS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .reflect(reflect_b), .line_start(line_start_b), .pf_out(pf_b), .active(act_b), .right_half(rh_b)
  );

  always #5 clk = ~clk;

  // Reference pixel for clock t after line_start: bit position by elapsed cells, mirrored in right half.
  function automatic logic model_pix(input logic [31:0] p, input logic r, input int t, input int n, input int c);
    int half, pos, b;
    if (t >= 2 * n * c) return 1'b0;
    half = t / (n * c);
    pos  = (t % (n * c)) / c;
    b    = (half == 1 && r) ? (n - 1 - pos) : pos;
    return p[b];
  endfunction

  function automatic exp_t model_a(input logic [31:0] p, input logic r, input int t);
    exp_t e;
    e.pf  = model_pix(p, r, t, 20, 4);
    e.act = (t < 160);
    e.rh  = (t >= 80) && (t < 160);
    return e;
  endfunction

  task automatic write_a(input logic [1:0] a, input logic [7:0] d);
    wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
    @(posedge clk); #1;
    wr_en_a = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] a, input logic [7:0] d);
    wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d;
    @(posedge clk); #1;
    wr_en_b = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({pf_a, act_a, rh_a} !== 3'b000) begin
      bad++; $display("FAIL reset_a got=%b want=000", {pf_a, act_a, rh_a});
    end
    total++;
    if ({pf_b, act_b, rh_b} !== 3'b000) begin
      bad++; $display("FAIL reset_b got=%b want=000", {pf_b, act_b, rh_b});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: outputs checked");
  endtask

  task automatic test_idle_write;
    write_a(2'd0, 8'hFF);
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      total++;
      if ({pf_a, act_a, rh_a} !== 3'b000) begin
        bad++; $display("FAIL idle_write t=%0d got=%b want=000", t, {pf_a, act_a, rh_a});
      end
    end
    $display("idle_write: 4 cycles checked");
  endtask

  task automatic test_basic;
    exp_t e;
    write_a(2'd0, 8'h01); write_a(2'd1, 8'h00); write_a(2'd2, 8'h00);
    reflect_a = 1'b0;
    line_start_a = 1'b1;
    for (int t = 0; t < 164; t++) begin
      sb.push_back(model_a(32'h00001, 1'b0, t));
      @(posedge clk); #1;
      line_start_a = 1'b0;
      e = sb.pop_front();
      total++;
      if ({pf_a, act_a, rh_a} !== e) begin
        bad++; $display("FAIL basic t=%0d got=%b want=%b", t, {pf_a, act_a, rh_a}, e);
      end
    end
    $display("line basic: 164 cycles checked");
  endtask

  task automatic test_reflect;
    exp_t e;
    reflect_a = 1'b1;
    line_start_a = 1'b1;
    for (int t = 0; t < 164; t++) begin
      if (t > 80) reflect_a = 1'($urandom_range(0, 1));
      sb.push_back(model_a(32'h00001, 1'b1, t));
      @(posedge clk); #1;
      line_start_a = 1'b0;
      e = sb.pop_front();
      total++;
      if ({pf_a, act_a, rh_a} !== e) begin
        bad++; $display("FAIL reflect t=%0d got=%b want=%b", t, {pf_a, act_a, rh_a}, e);
      end
    end
    reflect_a = 1'b0;
    $display("line reflect: 164 cycles checked");
  endtask

  task automatic test_write_on_start;
    exp_t e;
    write_a(2'd0, 8'h00); write_a(2'd1, 8'h00); write_a(2'd2, 8'h00);
    wr_en_a = 1'b1; wr_addr_a = 2'd0; wr_data_a = 8'hFF;
    line_start_a = 1'b1;
    for (int t = 0; t < 164; t++) begin
      e = model_a(32'h000FF, 1'b0, t);
      if (t < 4) e.pf = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      line_start_a = 1'b0; wr_en_a = 1'b0;
      e = sb.pop_front();
      total++;
      if ({pf_a, act_a, rh_a} !== e) begin
        bad++; $display("FAIL write_on_start t=%0d got=%b want=%b", t, {pf_a, act_a, rh_a}, e);
      end
    end
    $display("line write_on_start: 164 cycles checked");
  endtask

  task automatic test_restart;
    exp_t e;
    write_a(2'd0, 8'hC1); write_a(2'd1, 8'hA3); write_a(2'd2, 8'h05);
    for (int t = 0; t < 214; t++) begin
      line_start_a = (t == 0 || t == 50);
      sb.push_back((t < 50) ? model_a(32'h5A3C1, 1'b0, t) : model_a(32'h5A3C1, 1'b0, t - 50));
      @(posedge clk); #1;
      line_start_a = 1'b0;
      e = sb.pop_front();
      total++;
      if ({pf_a, act_a, rh_a} !== e) begin
        bad++; $display("FAIL restart t=%0d got=%b want=%b", t, {pf_a, act_a, rh_a}, e);
      end
    end
    $display("line restart: 214 cycles checked");
  endtask

  task automatic test_reset_midline;
    exp_t e;
    write_a(2'd0, 8'hFF); write_a(2'd1, 8'hFF); write_a(2'd2, 8'hFF);
    line_start_a = 1'b1;
    for (int t = 0; t <= 100; t++) begin
      sb.push_back(model_a(32'hFFFFF, 1'b0, t));
      @(posedge clk); #1;
      line_start_a = 1'b0;
      e = sb.pop_front();
      total++;
      if ({pf_a, act_a, rh_a} !== e) begin
        bad++; $display("FAIL pre_reset t=%0d got=%b want=%b", t, {pf_a, act_a, rh_a}, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({pf_a, act_a, rh_a} !== 3'b000) begin
      bad++; $display("FAIL async_reset got=%b want=000", {pf_a, act_a, rh_a});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      total++;
      if ({pf_a, act_a, rh_a} !== 3'b000) begin
        bad++; $display("FAIL post_reset_idle t=%0d got=%b want=000", t, {pf_a, act_a, rh_a});
      end
    end
    line_start_a = 1'b1;
    for (int t = 0; t < 164; t++) begin
      sb.push_back(model_a(32'h00000, 1'b0, t));
      @(posedge clk); #1;
      line_start_a = 1'b0;
      e = sb.pop_front();
      total++;
      if ({pf_a, act_a, rh_a} !== e) begin
        bad++; $display("FAIL post_reset_line t=%0d got=%b want=%b", t, {pf_a, act_a, rh_a}, e);
      end
    end
    $display("line reset_midline: aborted line and cleared pattern checked");
  endtask

  task automatic test_small_reflect;
    exp_t e;
    logic [15:0] pat;
    pat = 16'b1000000110000001;
    write_b(2'd0, 8'h81); write_b(2'd1, 8'hFF);
    reflect_b = 1'b1;
    line_start_b = 1'b1;
    for (int t = 0; t < 18; t++) begin
      e.pf  = (t < 16) ? pat[15 - t] : 1'b0;
      e.act = (t < 16);
      e.rh  = (t >= 8) && (t < 16);
      sb.push_back(e);
      @(posedge clk); #1;
      line_start_b = 1'b0;
      e = sb.pop_front();
      total++;
      if ({pf_b, act_b, rh_b} !== e) begin
        bad++; $display("FAIL small_reflect t=%0d got=%b want=%b", t, {pf_b, act_b, rh_b}, e);
      end
    end
    $display("line small_reflect: 18 cycles checked");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    reflect_b = 1'b0;
    write_b(2'd0, 8'h35);
    for (int t = 0; t < 34; t++) begin
      line_start_b = (t == 0 || t == 16);
      reflect_b    = (t >= 16);
      e.pf  = model_pix(32'h35, (t >= 16), t % 16, 8, 1) & (t < 32);
      e.act = (t < 32);
      e.rh  = ((t % 16) >= 8) && (t < 32);
      sb.push_back(e);
      @(posedge clk); #1;
      line_start_b = 1'b0;
      e = sb.pop_front();
      total++;
      if ({pf_b, act_b, rh_b} !== e) begin
        bad++; $display("FAIL back_to_back t=%0d got=%b want=%b", t, {pf_b, act_b, rh_b}, e);
      end
    end
    $display("line back_to_back: 34 cycles checked");
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en_a = 1'b0; wr_addr_a = 2'd0; wr_data_a = 8'h00; reflect_a = 1'b0; line_start_a = 1'b0;
    wr_en_b = 1'b0; wr_addr_b = 2'd0; wr_data_b = 8'h00; reflect_b = 1'b0; line_start_b = 1'b0;
    test_reset;
    test_idle_write;
    test_basic;
    test_reflect;
    test_write_on_start;
    test_restart;
    test_reset_midline;
    test_small_reflect;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tia_playfield_serializer.md
TIA_PLAYFIELD_SERIALIZER -- requirements
Module: tia_playfield_serializer

Interface
REQ-001 Parameter PF_BITS, default 20, playfield bits per half-line; legal 8..32.
REQ-002 Parameter CELL_CLKS, default 4, clocks each playfield bit is held; legal 1..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  byte write strobe, sampled on clk.
REQ-006 wr_addr  input  2  byte lane select; lane a covers pf_reg bits [8a+7:8a].
REQ-007 wr_data  input  8  write data.
REQ-008 reflect  input  1  right-half mirror mode, sampled only at left-to-right transition.
REQ-009 line_start  input  1  one-clock pulse starting a playfield line.
REQ-010 pf_out  output  1  registered playfield pixel.
REQ-011 active  output  1  high while in LEFT or RIGHT.
REQ-012 right_half  output  1  high while in RIGHT.

Function
REQ-013 pf_reg SHALL be PF_BITS wide; a write SHALL update lane bits below PF_BITS only; lane bits at or above PF_BITS and lanes wholly above PF_BITS SHALL be ignored.
REQ-014 A write SHALL land in pf_reg on the sampling edge; a pixel load on that same edge SHALL use the pre-write pf_reg value.
REQ-015 State machine SHALL have states IDLE, LEFT, RIGHT; internal bit index idx (0..PF_BITS-1) and cell counter cnt (0..CELL_CLKS-1).
REQ-016 line_start=1 sampled in any state SHALL force state LEFT, idx=0, cnt=0, pf_out=pf_reg[0] on that edge (restart mid-line permitted).
REQ-017 In LEFT/RIGHT without line_start, cnt SHALL increment each clock; at cnt=CELL_CLKS-1 cnt SHALL wrap to 0 and the next bit SHALL load into pf_out.
REQ-018 LEFT order SHALL be idx 0,1,...,PF_BITS-1.
REQ-019 After LEFT bit PF_BITS-1 completes, state SHALL become RIGHT, reflect SHALL be latched into refl_q on that edge, and pf_out SHALL load pf_reg[PF_BITS-1] if reflect=1 else pf_reg[0].
REQ-020 RIGHT order SHALL be PF_BITS-1 down to 0 when refl_q=1, else 0 up to PF_BITS-1; reflect changes during RIGHT SHALL be ignored.
REQ-021 After RIGHT's final bit completes, state SHALL become IDLE and pf_out SHALL be 0.
REQ-022 A full line SHALL occupy exactly 2*PF_BITS*CELL_CLKS clocks of active=1; latency line_start edge to first pixel SHALL be 0 clocks (pf_out valid after that edge).
REQ-023 In IDLE pf_out SHALL stay 0 and writes SHALL still update pf_reg.
REQ-024 CELL_CLKS=1 SHALL advance one bit every clock with no idle gap between halves.
REQ-025 active and right_half SHALL be registered, decoded from state, aligned with pf_out.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, pf_reg=0, idx=0, cnt=0, refl_q=0, pf_out=0, active=0, right_half=0.
REQ-027 Reset asserted mid-line SHALL abort the line; after release the block SHALL remain IDLE until line_start.
REQ-028 Release of rst_n SHALL be synchronised to clk by the integrator; first sampled edge after release behaves as normal operation.

Verification
REQ-029 Defaults, pf_reg=0x00001 (lanes 0..2 = 01,00,00), reflect=0, line_start -> pf_out=1 for clocks 0-3 and 80-83, 0 elsewhere; active high for 160 clocks.
REQ-030 Same pf_reg, reflect=1 held through clock 79 -> pf_out=1 for clocks 0-3 and 156-159; reflect toggled during clocks 80-159 has no effect.
REQ-031 Write lane 0=0xFF on the line_start edge with prior pf_reg=0 -> first pixel 0, bits 1-7 output 1 (clocks 4-31 high).
REQ-032 line_start reissued at clock 50 -> pf_out restarts at bit 0, active stays high, line ends 160 clocks after second pulse.
REQ-033 rst_n low at clock 100 -> pf_out, active, right_half 0 immediately; pf_reg reads back 0 on next line.
REQ-034 PF_BITS=8, CELL_CLKS=1, pf_reg=0x81 write to lane 1 ignored, reflect=1 -> pf_out pattern 1000000110000001 over 16 clocks.
